// File: rtl/gbsha_fir_mac.sv
// N-tap signed FIR filter sharing one multiplier across taps. Coefficients are
// loaded serially through the sample port; outputs are shifted and saturated.
module gbsha_fir_mac #(
  parameter int N_TAPS = 4,
  parameter int BW_in  = 6,
  parameter int BW_out = 8,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [BW_in-1:0]  x_in,
  output logic signed [BW_out-1:0] y_out,
  output logic                     y_valid,
  output logic                     loaded
);

  localparam int BW_acc = 2*BW_in + $clog2(N_TAPS) + 1;
  localparam int IDX_W  = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TAPS - 1);

  localparam logic signed [BW_acc-1:0] SAT_MAX = BW_acc'((2**(BW_out-1)) - 1);
  localparam logic signed [BW_acc-1:0] SAT_MIN = BW_acc'(-(2**(BW_out-1)));

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_MAC  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  logic [1:0]                 state_reg, state_next;
  logic [IDX_W-1:0]           idx_reg, idx_next;
  logic signed [BW_acc-1:0]   acc_reg, acc_next;
  logic signed [BW_out-1:0]   y_out_reg, y_out_next;

  logic signed [BW_in-1:0]    coef_reg   [N_TAPS];
  logic signed [BW_in-1:0]    x_reg      [N_TAPS];
  logic signed [BW_in-1:0]    x_shift_in [N_TAPS];

  logic                       accept;
  logic                       coef_we;
  logic                       x_shift;
  logic                       x_clear;
  logic signed [2*BW_in-1:0]  prod;
  logic signed [BW_acc-1:0]   acc_sum;
  logic signed [BW_acc-1:0]   acc_shifted;
  logic signed [BW_out-1:0]   sat_val;

  assign in_ready = reset_n && !load && (state_reg == ST_LOAD || state_reg == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign loaded   = (state_reg != ST_LOAD);
  assign y_valid  = (state_reg == ST_OUT);
  assign y_out    = y_out_reg;

  // Tap 0 takes the new sample, every other tap takes its older neighbour.
  generate
    for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_shift
      if (gi == 0) begin : g_head
        assign x_shift_in[gi] = x_in;
      end else begin : g_tail
        assign x_shift_in[gi] = x_reg[gi-1];
      end
    end
  endgenerate

  assign prod        = x_reg[idx_reg] * coef_reg[idx_reg];
  assign acc_sum     = acc_reg + {{(BW_acc-2*BW_in){prod[2*BW_in-1]}}, prod};
  assign acc_shifted = acc_sum >>> SHIFT;

  always_comb begin
    sat_val = acc_shifted[BW_out-1:0];
    if (acc_shifted > SAT_MAX) begin
      sat_val = SAT_MAX[BW_out-1:0];
    end else if (acc_shifted < SAT_MIN) begin
      sat_val = SAT_MIN[BW_out-1:0];
    end
  end

  // The result register is written on the last MAC edge so that y_out is
  // already valid during the cycle in which y_valid is high.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    acc_next   = acc_reg;
    y_out_next = y_out_reg;
    coef_we    = 1'b0;
    x_shift    = 1'b0;
    x_clear    = 1'b0;
    if (load) begin
      state_next = ST_LOAD;
      idx_next   = '0;
      acc_next   = '0;
      x_clear    = 1'b1;
    end else begin
      case (state_reg)
        ST_LOAD: begin
          if (accept) begin
            coef_we = 1'b1;
            if (idx_reg == LAST_IDX) begin
              state_next = ST_IDLE;
              idx_next   = '0;
            end else begin
              idx_next = idx_reg + IDX_W'(1);
            end
          end
        end
        ST_IDLE: begin
          if (accept) begin
            x_shift    = 1'b1;
            acc_next   = '0;
            idx_next   = '0;
            state_next = ST_MAC;
          end
        end
        ST_MAC: begin
          acc_next = acc_sum;
          if (idx_reg == LAST_IDX) begin
            idx_next   = '0;
            y_out_next = sat_val;
            state_next = ST_OUT;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_LOAD;
      idx_reg   <= '0;
      acc_reg   <= '0;
      y_out_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      acc_reg   <= acc_next;
      y_out_reg <= y_out_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_TAPS; i++) begin
        x_reg[i]    <= '0;
        coef_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_TAPS; i++) begin
        if (x_clear) begin
          x_reg[i] <= '0;
        end else if (x_shift) begin
          x_reg[i] <= x_shift_in[i];
        end
        if (coef_we && idx_reg == IDX_W'(i)) begin
          coef_reg[i] <= x_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_gbsha_fir_mac.sv
// Directed bench for gbsha_fir_mac: a SHIFT=0 and a SHIFT=4 instance share the
// same stimulus; expected outputs are hand-computed per vector.
module tb_gbsha_fir_mac;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              load = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [5:0] x_in = '0;
  logic              in_ready, in_ready_s4;
  logic signed [7:0] y_out, y_out_s4;
  logic              y_valid, y_valid_s4;
  logic              loaded, loaded_s4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  gbsha_fir_mac #(.N_TAPS(4), .BW_in(6), .BW_out(8), .SHIFT(0)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .in_valid(in_valid),
    .in_ready(in_ready), .x_in(x_in), .y_out(y_out), .y_valid(y_valid),
    .loaded(loaded)
  );

  gbsha_fir_mac #(.N_TAPS(4), .BW_in(6), .BW_out(8), .SHIFT(4)) dut_s4 (
    .clk(clk), .reset_n(reset_n), .load(load), .in_valid(in_valid),
    .in_ready(in_ready_s4), .x_in(x_in), .y_out(y_out_s4), .y_valid(y_valid_s4),
    .loaded(loaded_s4)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic load_coefs(input int c[4], input bit pulse);
    if (pulse) begin
      @(negedge clk);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("loaded_low_while_loading", loaded, 0);
      chk("ready_while_loading", in_ready, 1);
      in_valid = 1'b1;
      x_in     = 6'(c[i]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("loaded_after_4th_coef", loaded, 1);
    $display("coef load %0d %0d %0d %0d loaded=%0d", c[0], c[1], c[2], c[3], loaded);
  endtask

  task automatic accept_sample(input int v);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_sample", in_ready, 1);
    in_valid = 1'b1;
    x_in     = 6'(v);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int exp0, input int exp4);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!y_valid && n < 20);
    chk({tag, "_latency"}, n, 5);
    chk({tag, "_y"}, y_out, exp0);
    chk({tag, "_y_shift4"}, y_out_s4, exp4);
    $display("txn %s: y_out=%0d y_out_shift4=%0d latency=%0d", tag, y_out, y_out_s4, n);
  endtask

  initial begin
    int seen;

    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_y_out", y_out, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_loaded", loaded, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_loaded", loaded, 0);

    // Pass-through coefficient.
    load_coefs('{1, 0, 0, 0}, 1'b0);
    accept_sample(5);
    expect_out("t1_a", 5, 0);
    accept_sample(-3);
    expect_out("t1_b", -3, -1);

    // Impulse response walks through the coefficients.
    load_coefs('{1, 2, 3, 4}, 1'b1);
    accept_sample(1); expect_out("t2_0", 1, 0);
    accept_sample(0); expect_out("t2_1", 2, 0);
    accept_sample(0); expect_out("t2_2", 3, 0);
    accept_sample(0); expect_out("t2_3", 4, 0);
    accept_sample(0); expect_out("t2_4", 0, 0);

    // Saturation at both rails; 1024/2048/3072/4096 and -992 and 64.
    load_coefs('{-32, -32, -32, -32}, 1'b1);
    accept_sample(-32); expect_out("t3_p1", 127, 64);
    accept_sample(-32); expect_out("t3_p2", 127, 127);
    accept_sample(-32); expect_out("t3_p3", 127, 127);
    accept_sample(-32); expect_out("t3_p4", 127, 127);
    load_coefs('{31, 0, 0, 0}, 1'b1);
    accept_sample(-32); expect_out("t3_neg", -128, -62);
    load_coefs('{8, 0, 0, 0}, 1'b1);
    accept_sample(8); expect_out("t3_64", 64, 4);

    // in_valid held high: one accept every 6 cycles, none during MAC/OUT.
    load_coefs('{1, 1, 1, 1}, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = 6'sd7;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("t4_ready_c%0d", c), in_ready, (c % 6 == 0) ? 1 : 0);
      chk($sformatf("t4_valid_c%0d", c), y_valid, (c % 6 == 5) ? 1 : 0);
      if (c % 6 == 5) begin
        chk($sformatf("t4_y_c%0d", c), y_out, (c / 6 < 4) ? 7 * (c / 6 + 1) : 28);
        $display("txn t4 cycle %0d: y_out=%0d", c, y_out);
      end
    end
    in_valid = 1'b0;

    // load raised in the OUT cycle: that result still appears (2+7+7+7).
    accept_sample(2);
    repeat (5) @(negedge clk);
    load = 1'b1;
    chk("t5_out_valid_under_load", y_valid, 1);
    chk("t5_out_y_under_load", y_out, 23);
    @(negedge clk);
    load = 1'b0;
    chk("t5_out_loaded_cleared", loaded, 0);
    chk("t5_out_no_second_valid", y_valid, 0);
    load_coefs('{1, 1, 1, 1}, 1'b0);

    // load in the 2nd MAC cycle aborts the sample.
    accept_sample(9);
    repeat (2) @(negedge clk);
    load = 1'b1;
    chk("t5_ready_low_under_load", in_ready, 0);
    @(negedge clk);
    load = 1'b0;
    chk("t5_loaded_cleared", loaded, 0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (y_valid) seen++;
    end
    chk("t5_no_y_valid_after_abort", seen, 0);
    chk("t5_y_out_held", y_out, 23);
    // Non-zero upper taps expose any delay-line history left behind.
    load_coefs('{2, 1, 1, 1}, 1'b0);
    accept_sample(3); expect_out("t5_reload", 6, 0);

    // Asynchronous reset in the middle of MAC.
    accept_sample(5);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_y_out_async", y_out, 0);
    chk("t6_y_valid_async", y_valid, 0);
    chk("t6_loaded_async", loaded, 0);
    chk("t6_ready_async", in_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t6_loaded_after_release", loaded, 0);
    load_coefs('{1, 0, 0, 0}, 1'b0);
    accept_sample(9); expect_out("t6_after", 9, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
